// File: rtl/rr_arbiter_4x2_if.sv
// Requester-side handshake bundle for the 4-way round-robin arbiter.
// The "done" pulse is named gnt_release because "release" is a reserved word.
interface rr_arbiter_4x2_if;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  logic [N_REQ-1:0] req;
  logic             gnt_release;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_onehot;
  logic             timeout;

  // Requester side drives requests and the release pulse.
  modport master (
    output req, gnt_release,
    input  gnt_vld, gnt_idx, gnt_onehot, timeout
  );

  // Arbiter side owns the grant outputs.
  modport slave (
    input  req, gnt_release,
    output gnt_vld, gnt_idx, gnt_onehot, timeout
  );
endinterface

// File: rtl/rr_arbiter_4x2.sv
// Round-robin arbiter: four requesters share one resource, grant held until
// release, request drop, or MAX_HOLD expiry; one idle bubble between grants.
module rr_arbiter_4x2 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_arbiter_4x2_if.slave   bus
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned HCW   = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HCW-1:0]   hold_cnt;

  logic             gnt_vld_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [N_REQ-1:0] gnt_onehot_q;
  logic             timeout_q;

  logic [IDX_W-1:0] win_idx_c;
  logic             win_found_c;
  logic [IDX_W-1:0] cand_c;
  logic             owner_done_c;
  logic             expire_c;

  // Priority scan starting at ptr; scanned backwards so offset 0 wins last.
  always_comb begin
    win_idx_c   = ptr;
    win_found_c = 1'b0;
    cand_c      = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_c = ptr + IDX_W'(k);
      if (bus.req[cand_c]) begin
        win_idx_c   = cand_c;
        win_found_c = 1'b1;
      end
    end
  end

  // Exit conditions while a grant is active; owner release beats expiry.
  always_comb begin
    owner_done_c = bus.gnt_release || !bus.req[gnt_idx_q];
    expire_c     = (hold_cnt == HCW'(MAX_HOLD));
  end

  // State, pointer, hold counter and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      hold_cnt     <= '0;
      gnt_vld_q    <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found_c) begin
            state        <= GRANT;
            gnt_vld_q    <= 1'b1;
            gnt_idx_q    <= win_idx_c;
            gnt_onehot_q <= N_REQ'(1) << win_idx_c;
            hold_cnt     <= HCW'(1);
          end
        end
        GRANT: begin
          if (owner_done_c || expire_c) begin
            state        <= IDLE;
            gnt_vld_q    <= 1'b0;
            gnt_onehot_q <= '0;
            ptr          <= gnt_idx_q + IDX_W'(1);
            timeout_q    <= !owner_done_c;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_vld    = gnt_vld_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4x2.sv
// Directed bench for rr_arbiter_4x2 with a reference-model scoreboard.
module tb_rr_arbiter_4x2;

  localparam int unsigned MAX_HOLD = 8;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
    logic [3:0] oh;
    logic       to;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_age;

  rr_arbiter_4x2_if bus ();

  rr_arbiter_4x2 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_age   = 0;
  endtask

  // Advance the model by one clock edge and return the expected outputs.
  task automatic model_step(input logic [3:0] r, input logic rl, output exp_t e);
    int  w;
    bit  to;
    to = 1'b0;
    if (!m_busy) begin
      w = -1;
      for (int s = 0; s < 4; s++)
        if (w < 0 && r[(m_ptr + s) % 4]) w = (m_ptr + s) % 4;
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_age   = 1;
      end
    end else if (rl || !r[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 4;
    end else if (m_age == int'(MAX_HOLD)) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 4;
      to     = 1'b1;
    end else begin
      m_age++;
    end
    e.vld = m_busy;
    e.idx = 2'(m_owner);
    e.oh  = m_busy ? 4'(1 << m_owner) : 4'b0000;
    e.to  = to;
  endtask

  // Drive one cycle of stimulus, push the expectation, compare after the edge.
  task automatic cyc(input logic [3:0] r, input logic rl);
    exp_t e;
    bus.req         = r;
    bus.gnt_release = rl;
    model_step(r, rl, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt_vld",    8'(bus.gnt_vld),    8'(e.vld));
    if (e.vld) chk("gnt_idx", 8'(bus.gnt_idx), 8'(e.idx));
    chk("gnt_onehot", 8'(bus.gnt_onehot), 8'(e.oh));
    chk("timeout",    8'(bus.timeout),    8'(e.to));
  endtask

  int hi_cnt;
  int to_at;

  initial begin
    checks          = 0;
    failures        = 0;
    bus.req         = 4'b0000;
    bus.gnt_release = 1'b0;
    rst_n           = 1'b1;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld",    8'(bus.gnt_vld),    8'h00);
    chk("rst_idx",    8'(bus.gnt_idx),    8'h00);
    chk("rst_onehot", 8'(bus.gnt_onehot), 8'h00);
    chk("rst_timeout",8'(bus.timeout),    8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single requester with release, then re-grant
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0100, 1'b0);
    chk("single_idx", 8'(bus.gnt_idx), 8'h02);
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b1);
    chk("single_exit_vld", 8'(bus.gnt_vld), 8'h00);
    cyc(4'b0100, 1'b0);
    chk("single_regrant", 8'(bus.gnt_idx), 8'h02);
    cyc(4'b0100, 1'b1);

    // Wrap and skip: ptr=3, req=1001
    cyc(4'b1001, 1'b0);
    chk("wrap_idx3", 8'(bus.gnt_idx), 8'h03);
    cyc(4'b1001, 1'b0);
    cyc(4'b1001, 1'b1);
    cyc(4'b1001, 1'b0);
    chk("wrap_idx0", 8'(bus.gnt_idx), 8'h00);
    cyc(4'b1001, 1'b1);
    cyc(4'b0000, 1'b0);

    // Asynchronous reset mid-grant on requester 2
    cyc(4'b0100, 1'b0);
    chk("pre_rst_idx", 8'(bus.gnt_idx), 8'h02);
    cyc(4'b0100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld",    8'(bus.gnt_vld),    8'h00);
    chk("async_rst_onehot", 8'(bus.gnt_onehot), 8'h00);
    chk("async_rst_timeout",8'(bus.timeout),    8'h00);
    model_reset();
    bus.req = 4'b0000;
    #2 rst_n = 1'b1;

    // Rotation with all four requesting
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 1'b0);
      chk("rot_idx", 8'(bus.gnt_idx), 8'(g % 4));
      cyc(4'b1111, 1'b0);
      cyc(4'b1111, 1'b1);
      chk("rot_bubble", 8'(bus.gnt_vld), 8'h00);
    end
    cyc(4'b0000, 1'b0);

    // Timeout: single requester 1, never releases
    hi_cnt = 0;
    to_at  = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0010, 1'b0);
      if (i < 9 && bus.gnt_vld === 1'b1) hi_cnt++;
      if (bus.timeout === 1'b1) to_at = i;
    end
    chk("to_hold_cycles", 8'(hi_cnt), 8'(MAX_HOLD));
    chk("to_pulse_at",    8'(to_at),  8'(MAX_HOLD));
    chk("to_regrant_idx", 8'(bus.gnt_idx), 8'h01);
    cyc(4'b0010, 1'b1);
    cyc(4'b0000, 1'b0);

    // Release on the same edge as expiry: normal exit
    cyc(4'b0010, 1'b0);
    for (int i = 0; i < int'(MAX_HOLD) - 1; i++) cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b1);
    chk("coll_timeout", 8'(bus.timeout), 8'h00);
    chk("coll_vld",     8'(bus.gnt_vld), 8'h00);
    cyc(4'b0000, 1'b0);

    // Non-owner toggling ignored, then owner drops its request
    cyc(4'b0100, 1'b0);
    cyc(4'b1101, 1'b0);
    cyc(4'b0110, 1'b0);
    cyc(4'b1111, 1'b0);
    chk("toggle_idx", 8'(bus.gnt_idx), 8'h02);
    cyc(4'b1011, 1'b0);
    chk("drop_vld", 8'(bus.gnt_vld), 8'h00);
    cyc(4'b1011, 1'b0);
    chk("drop_next_idx", 8'(bus.gnt_idx), 8'h03);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
